// File: rtl/frv_wb_pkg.sv
// Shared types for the FazyRV imem/dmem Wishbone arbiter.
// Grant states, request bundle and the watchdog width helper.
package frv_wb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D
  } arb_state_e;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  be;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

  localparam logic [3:0] IMEM_BE = 4'hF;

  function automatic int cnt_w(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/frv_wb_watchdog.sv
// Bus watchdog: counts unacknowledged granted cycles and forces
// completion once TIMEOUT cycles have elapsed; keeps a sticky flag.
module frv_wb_watchdog
  import frv_wb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic ack_i,
  output logic expire_o,
  output logic flag_o
);

  localparam bit EN = (TIMEOUT > 0);
  localparam int CW = cnt_w(TIMEOUT);
  localparam int LIM = EN ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] LAST = CW'(LIM);

  logic [CW-1:0] cnt;

  // Fires in the cycle the count reaches TIMEOUT; a real ack wins.
  assign expire_o = EN && active_i && !ack_i && (cnt == LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i || !EN || !active_i || ack_i || expire_o) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flag_o <= 1'b0;
    end else if (expire_o) begin
      flag_o <= 1'b1;
    end
  end

endmodule

// File: rtl/frv_wb_arbiter.sv
// Two-master (imem/dmem) to one-slave Wishbone classic arbiter
// with fixed-dmem or round-robin priority and a bus watchdog.
module frv_wb_arbiter
  import frv_wb_pkg::*;
#(
  parameter string       PRIO    = "DMEM",
  parameter int          TIMEOUT = 255,
  parameter logic [31:0] TO_DATA = 32'hFFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        s_imem_cyc_i,
  input  logic        s_imem_stb_i,
  input  logic [31:0] s_imem_adr_i,
  output logic [31:0] s_imem_dat_o,
  output logic        s_imem_ack_o,
  input  logic        s_dmem_cyc_i,
  input  logic        s_dmem_stb_i,
  input  logic        s_dmem_we_i,
  input  logic [3:0]  s_dmem_be_i,
  input  logic [31:0] s_dmem_adr_i,
  input  logic [31:0] s_dmem_dat_i,
  output logic [31:0] s_dmem_dat_o,
  output logic        s_dmem_ack_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [3:0]  m_be_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  output logic        timeout_o
);

  localparam bit RR = (PRIO == "RR");

  arb_state_e state, state_nx;
  wb_req_t    ireq, dreq, mreq;
  logic       i_req, d_req, pick_d;
  logic       last_i, expire, done;

  assign ireq = '{cyc: s_imem_cyc_i, stb: s_imem_stb_i,
                  we: 1'b0, be: IMEM_BE,
                  adr: s_imem_adr_i, dat: '0};
  assign dreq = '{cyc: s_dmem_cyc_i, stb: s_dmem_stb_i,
                  we: s_dmem_we_i, be: s_dmem_be_i,
                  adr: s_dmem_adr_i, dat: s_dmem_dat_i};

  assign i_req = ireq.cyc & ireq.stb;
  assign d_req = dreq.cyc & dreq.stb;
  // RR: dmem wins a tie only if imem was granted last
  assign pick_d = d_req & (!i_req | !RR | last_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_i <= 1'b0;
    end else if (state == IDLE && (i_req | d_req)) begin
      last_i <= !pick_d;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (i_req | d_req) begin
          state_nx = pick_d ? GNT_D : GNT_I;
        end
      end
      GNT_I, GNT_D: begin
        if (!mreq.cyc || m_ack_i || expire) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mreq = '0;
    unique case (state)
      GNT_I:   mreq = ireq;
      GNT_D:   mreq = dreq;
      default: mreq = '0;
    endcase
  end

  frv_wb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .active_i(mreq.cyc & mreq.stb),
    .ack_i   (m_ack_i),
    .expire_o(expire),
    .flag_o  (timeout_o)
  );

  assign done = mreq.cyc & (m_ack_i | expire);

  assign m_cyc_o = (state != IDLE) & !expire;
  assign m_stb_o = m_cyc_o;
  assign m_we_o  = mreq.we;
  assign m_be_o  = mreq.be;
  assign m_adr_o = mreq.adr;
  assign m_dat_o = mreq.dat;

  assign s_imem_ack_o = (state == GNT_I) & done;
  assign s_dmem_ack_o = (state == GNT_D) & done;
  assign s_imem_dat_o = expire ? TO_DATA : m_dat_i;
  assign s_dmem_dat_o = expire ? TO_DATA : m_dat_i;

endmodule

// File: tb/tb_frv_wb_arbiter.sv
// Self-checking bench: instance 0 fixed dmem priority, instance 1
// round-robin, both with a 4-cycle watchdog.
module tb_frv_wb_arbiter;

  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst, icyc, istb, dcyc, dstb, dwe, mack;
  logic [3:0]  dbe [2];
  logic [31:0] iadr[2], dadr[2], ddat[2], mdat[2];
  logic [31:0] idat[2], dat_d[2], madr[2], mwd[2];
  logic [3:0]  mbe [2];
  logic [1:0]  iack, dack, mcyc, mstb, mwe, tmo;

  int checks = 0;
  int failures = 0;
  // reference model state per instance
  bit last_i_m[2];
  bit tmo_m[2];

  frv_wb_arbiter #(.PRIO("DMEM"), .TIMEOUT(TO)) u_fix (
    .clk_i(clk), .rst_i(rst[0]),
    .s_imem_cyc_i(icyc[0]), .s_imem_stb_i(istb[0]),
    .s_imem_adr_i(iadr[0]), .s_imem_dat_o(idat[0]),
    .s_imem_ack_o(iack[0]),
    .s_dmem_cyc_i(dcyc[0]), .s_dmem_stb_i(dstb[0]),
    .s_dmem_we_i(dwe[0]), .s_dmem_be_i(dbe[0]),
    .s_dmem_adr_i(dadr[0]), .s_dmem_dat_i(ddat[0]),
    .s_dmem_dat_o(dat_d[0]), .s_dmem_ack_o(dack[0]),
    .m_cyc_o(mcyc[0]), .m_stb_o(mstb[0]), .m_we_o(mwe[0]),
    .m_be_o(mbe[0]), .m_adr_o(madr[0]), .m_dat_o(mwd[0]),
    .m_dat_i(mdat[0]), .m_ack_i(mack[0]),
    .timeout_o(tmo[0])
  );

  frv_wb_arbiter #(.PRIO("RR"), .TIMEOUT(TO)) u_rr (
    .clk_i(clk), .rst_i(rst[1]),
    .s_imem_cyc_i(icyc[1]), .s_imem_stb_i(istb[1]),
    .s_imem_adr_i(iadr[1]), .s_imem_dat_o(idat[1]),
    .s_imem_ack_o(iack[1]),
    .s_dmem_cyc_i(dcyc[1]), .s_dmem_stb_i(dstb[1]),
    .s_dmem_we_i(dwe[1]), .s_dmem_be_i(dbe[1]),
    .s_dmem_adr_i(dadr[1]), .s_dmem_dat_i(ddat[1]),
    .s_dmem_dat_o(dat_d[1]), .s_dmem_ack_o(dack[1]),
    .m_cyc_o(mcyc[1]), .m_stb_o(mstb[1]), .m_we_o(mwe[1]),
    .m_be_o(mbe[1]), .m_adr_o(madr[1]), .m_dat_o(mwd[1]),
    .m_dat_i(mdat[1]), .m_ack_i(mack[1]),
    .timeout_o(tmo[1])
  );

  typedef struct {
    int          k;
    bit          ir;
    bit          dr;
    bit          we;
    logic [3:0]  be;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] dd;
    logic [31:0] rd;
    bit          exp_d;
  } vec_t;

  vec_t tv[5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop(input int k, input bit d);
    if (d) begin
      dcyc[k] = 1'b0;
      dstb[k] = 1'b0;
    end else begin
      icyc[k] = 1'b0;
      istb[k] = 1'b0;
    end
  endtask

  task automatic do_reset(input int k);
    drop(k, 1'b0);
    drop(k, 1'b1);
    mack[k] = 1'b0;
    rst[k] = 1'b1;
    tick();
    tick();
    rst[k] = 1'b0;
    last_i_m[k] = 1'b0;
    tmo_m[k] = 1'b0;
  endtask

  // Wait for a grant, act as the slave with lat wait states, check result.
  task automatic serve(input int k, input bit exp_d, input int lat,
                       input logic [31:0] rd);
    int t;
    int gend;
    bit real_ack;
    t = 0;
    mack[k] = 1'b0;
    mdat[k] = rd;
    #2;
    while (!mcyc[k] && t < 6) begin
      tick();
      t++;
      #1;
    end
    chk("grant_latency", t, 1);
    if (!mcyc[k]) return;
    chk("m_we", mwe[k], exp_d ? dwe[k] : 1'b0);
    chk("m_be", mbe[k], exp_d ? dbe[k] : 4'hF);
    chk("m_adr", madr[k], exp_d ? dadr[k] : iadr[k]);
    if (exp_d) chk("m_dat", mwd[k], ddat[k]);
    real_ack = (lat + 1 <= TO);
    gend = real_ack ? lat + 1 : TO;
    for (int g = 1; g <= gend; g++) begin
      if (g > 1) tick();
      mack[k] = (g == lat + 1);
      #2;
      if (g < gend) chk("early_ack", {iack[k], dack[k]}, 2'b00);
    end
    chk("ack_port", {iack[k], dack[k]}, exp_d ? 2'b01 : 2'b10);
    chk("ack_dat", exp_d ? dat_d[k] : idat[k],
        real_ack ? rd : 32'hFFFF_FFFF);
    chk("m_cyc_end", mcyc[k], real_ack);
    if (!real_ack) tmo_m[k] = 1'b1;
    last_i_m[k] = !exp_d;
  endtask

  task automatic session(input int k, input bit ir, input bit dr,
                         input bit first_d, input int l1, input int l2,
                         input logic [31:0] r1, input logic [31:0] r2);
    tick();
    icyc[k] = ir;
    istb[k] = ir;
    dcyc[k] = dr;
    dstb[k] = dr;
    serve(k, first_d, l1, r1);
    tick();
    mack[k] = 1'b0;
    drop(k, first_d);
    if (ir && dr) begin
      serve(k, !first_d, l2, r2);
      tick();
      mack[k] = 1'b0;
      drop(k, 1'b0);
      drop(k, 1'b1);
    end
    #2;
    chk("idle_after", mcyc[k], 1'b0);
    chk("timeout_flag", tmo[k], tmo_m[k]);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit");
    $fatal(1);
  end

  initial begin
    int k;
    int sel;
    bit ir, dr, fd;

    rst = 2'b11;
    icyc = '0; istb = '0; dcyc = '0; dstb = '0; dwe = '0; mack = '0;
    for (int i = 0; i < 2; i++) begin
      dbe[i] = '0; iadr[i] = '0; dadr[i] = '0;
      ddat[i] = '0; mdat[i] = '0;
    end

    tv[0] = '{k:0, ir:1, dr:0, we:0, be:4'h0, ia:32'h70, da:32'h0,
              dd:32'h0, rd:32'h13, exp_d:0};
    tv[1] = '{k:0, ir:1, dr:1, we:1, be:4'b0011, ia:32'h74,
              da:32'h1000, dd:32'hCAFEBABE, rd:32'h1111_1111, exp_d:1};
    tv[2] = '{k:0, ir:0, dr:1, we:0, be:4'hF, ia:32'h0,
              da:32'h2004, dd:32'h0, rd:32'hDEADBEEF, exp_d:1};
    tv[3] = '{k:1, ir:1, dr:1, we:1, be:4'b1100, ia:32'h80,
              da:32'h3000, dd:32'h1234_5678, rd:32'h55AA_55AA, exp_d:0};
    tv[4] = '{k:1, ir:0, dr:1, we:1, be:4'b0001, ia:32'h0,
              da:32'h3008, dd:32'h0000_00EE, rd:32'h0, exp_d:1};

    tick();
    tick();
    #2;
    for (int i = 0; i < 2; i++) begin
      chk("rst_cyc", mcyc[i], 1'b0);
      chk("rst_stb", mstb[i], 1'b0);
      chk("rst_we", mwe[i], 1'b0);
      chk("rst_be", mbe[i], 4'h0);
      chk("rst_adr", madr[i], 32'h0);
      chk("rst_dat", mwd[i], 32'h0);
      chk("rst_acks", {iack[i], dack[i]}, 2'b00);
      chk("rst_tmo", tmo[i], 1'b0);
    end
    rst = 2'b00;

    // table of single / dual request sessions with a zero-wait slave
    foreach (tv[i]) begin
      k = tv[i].k;
      do_reset(k);
      iadr[k] = tv[i].ia;
      dadr[k] = tv[i].da;
      ddat[k] = tv[i].dd;
      dwe[k] = tv[i].we;
      dbe[k] = tv[i].be;
      session(k, tv[i].ir, tv[i].dr, tv[i].exp_d, 0, 0,
              tv[i].rd, tv[i].rd + 32'd1);
    end

    // round robin with both masters requesting continuously
    do_reset(1);
    iadr[1] = 32'h100;
    dadr[1] = 32'h200;
    session(1, 1, 0, 0, 0, 0, 32'h1, 32'h0);
    tick();
    icyc[1] = 1'b1; istb[1] = 1'b1;
    dcyc[1] = 1'b1; dstb[1] = 1'b1;
    for (int n = 0; n < 6; n++) begin
      serve(1, (n % 2) == 0, 0, 32'hA0 + n);
      tick();
      mack[1] = 1'b0;
    end
    drop(1, 1'b0);
    drop(1, 1'b1);
    tick();
    #2;
    chk("rr_idle", mcyc[1], 1'b0);

    // watchdog expiry, then a normal transfer; flag stays set
    do_reset(0);
    dadr[0] = 32'h4000;
    dwe[0] = 1'b0;
    dbe[0] = 4'hF;
    session(0, 0, 1, 1, 100, 0, 32'h1234, 32'h0);
    session(0, 0, 1, 1, 1, 0, 32'h600D, 32'h0);

    // ack in the same cycle the watchdog would expire
    do_reset(0);
    session(0, 0, 1, 1, 3, 0, 32'hC0FFEE00, 32'h0);

    // reset in the 2nd granted cycle, slave acks a cycle later
    do_reset(0);
    tick();
    dcyc[0] = 1'b1; dstb[0] = 1'b1;
    dwe[0] = 1'b1; dbe[0] = 4'h3; ddat[0] = 32'h77;
    tick();
    tick();
    rst[0] = 1'b1;
    #2;
    chk("rst_mid_pre_cyc", mcyc[0], 1'b1);
    tick();
    rst[0] = 1'b0;
    mack[0] = 1'b1;
    mdat[0] = 32'hBAD0_BAD0;
    #2;
    chk("rst_mid_cyc", mcyc[0], 1'b0);
    chk("rst_mid_we", mwe[0], 1'b0);
    chk("rst_mid_be", mbe[0], 4'h0);
    chk("rst_mid_adr", madr[0], 32'h0);
    chk("rst_mid_dat", mwd[0], 32'h0);
    chk("rst_mid_acks", {iack[0], dack[0]}, 2'b00);
    tick();
    mack[0] = 1'b0;
    drop(0, 1'b1);

    // randomized sessions against the reference model
    do_reset(0);
    do_reset(1);
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(1, 0);
      sel = $urandom_range(3, 1);
      ir = sel[0];
      dr = sel[1];
      iadr[k] = $urandom;
      dadr[k] = $urandom;
      ddat[k] = $urandom;
      dwe[k] = 1'($urandom_range(1, 0));
      dbe[k] = 4'($urandom_range(15, 0));
      fd = dr && (!ir || k == 0 || last_i_m[k]);
      session(k, ir, dr, fd, $urandom_range(5, 0),
              $urandom_range(5, 0), $urandom, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frv_wb_arbiter.md
Name: frv_wb_arbiter

Overview:
- Two-master to one-slave Wishbone classic arbiter, placed directly downstream of the FazyRV core's imem and dmem ports.
- Merges both ports onto a single shared memory bus (unified SRAM/ROM macro), so a 1-bit core runs from one physical memory.
- Adds a bus watchdog: a hung slave cannot stall the core forever.

Parameters:
- PRIO, "DMEM", arbitration policy: "DMEM" = fixed dmem priority; "RR" = round-robin, last-granted loses ties.
- TIMEOUT, 255, maximum cycles a granted transfer waits for slave ack before the arbiter forces completion; 0 disables the watchdog.
- TO_DATA, 32'hFFFF_FFFF, read data returned on a forced (timeout) completion.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, synchronous reset, active-high.
- s_imem_cyc_i / s_imem_stb_i, in, 1 each, imem request from core.
- s_imem_adr_i, in, 32, imem address.
- s_imem_dat_o, out, 32, imem read data.
- s_imem_ack_o, out, 1, imem ack.
- s_dmem_cyc_i / s_dmem_stb_i / s_dmem_we_i, in, 1 each, dmem request.
- s_dmem_be_i, in, 4, byte enables.
- s_dmem_adr_i / s_dmem_dat_i, in, 32 each, dmem address / write data.
- s_dmem_dat_o, out, 32, dmem read data.
- s_dmem_ack_o, out, 1, dmem ack.
- m_cyc_o / m_stb_o / m_we_o, out, 1 each, shared bus request.
- m_be_o, out, 4, shared byte enables.
- m_adr_o / m_dat_o, out, 32 each, shared address / write data.
- m_dat_i, in, 32, shared read data.
- m_ack_i, in, 1, shared ack.
- timeout_o, out, 1, sticky flag: a watchdog completion has occurred.

Behaviour:
- FSM states: IDLE, GNT_I, GNT_D. Reset enters IDLE.
- Reset values: m_cyc_o=m_stb_o=m_we_o=0, m_be_o=0, m_adr_o=0, m_dat_o=0, both acks 0, timeout_o=0, watchdog counter 0, RR pointer = imem favoured.
- A request is cyc&stb. In IDLE, a request in cycle N moves the FSM to GNT_x at N+1.
  - PRIO "DMEM": dmem wins whenever both request.
  - PRIO "RR": on simultaneous requests, the master not granted last wins.
- GNT_x: m_cyc_o=m_stb_o=1. m_adr/dat/we/be are driven from the granted master; imem grant forces we=0 and be=4'hF. Muxes are combinational from state.
- m_ack_i is routed combinationally to the granted master's ack in the same cycle. m_dat_i goes to both s_*_dat_o; only the granted port's ack is asserted.
- On ack, the FSM returns to IDLE at the next edge. Consequences:
  - One mandatory idle cycle between transfers; m_cyc_o drops for at least one cycle.
  - Minimum latency, request to ack, is 2 cycles with a zero-wait slave.
- Masters must deassert stb the cycle after ack. The arbiter does not re-grant in that cycle because the FSM is in IDLE and samples only from the next cycle.
- Requester drops cyc while granted, without ack: return to IDLE next cycle, no ack issued, counter cleared.
- Watchdog: the counter increments each GNT_x cycle without m_ack_i and clears on entry to IDLE.
  - When the counter reaches TIMEOUT, the arbiter asserts the granted s_*_ack_o for one cycle with s_*_dat_o=TO_DATA, deasserts m_cyc_o/m_stb_o that same cycle, sets timeout_o, and goes to IDLE.
  - If m_ack_i arrives in the same cycle the counter reaches TIMEOUT, the real ack wins and timeout_o is not set.
- timeout_o clears only on rst_i.
- rst_i mid-transfer: all outputs take reset values at the next edge. A slave ack arriving after that is ignored and not routed.
- Counter width is clog2(TIMEOUT+1), minimum 1. It must not wrap.

Decomposition:
- Package frv_wb_pkg holds:
  - state enum arb_state_e {IDLE, GNT_I, GNT_D}
  - a wb_req_t struct {cyc, stb, we, be[3:0], adr[31:0], dat[31:0]}
  - constant IMEM_BE = 4'hF
- One sub-module is natural: frv_wb_watchdog (counter, expiry pulse, sticky flag), parameterised by TIMEOUT.

Test Plan:
- Single imem read, PRIO "DMEM", adr=0x70, slave acks with 0x00000013 in the first granted cycle -> m_cyc_o high at N+1, s_imem_ack_o=1 with dat 0x00000013 at N+1, m_cyc_o low at N+2.
- Simultaneous imem and dmem requests, PRIO "DMEM" -> dmem (adr 0x1000, we=1, be=4'b0011, dat 0xCAFEBABE) is granted first; imem is granted after the idle cycle, with m_we_o=0 and m_be_o=4'hF.
- PRIO "RR", both ports requesting continuously for 6 transfers -> grants alternate D,I,D,I,D,I when imem was last granted before the test; each transfer has an idle gap.
- Slave never acks, TIMEOUT=4 -> s_dmem_ack_o pulses on the 4th granted cycle with dat 0xFFFFFFFF, timeout_o=1 and stays 1; the next request proceeds normally.
- Slave ack in the same cycle the counter expires -> the real data is returned and timeout_o stays 0.
- rst_i asserted in the 2nd cycle of a granted dmem transfer, slave acks one cycle later -> all outputs are 0 after the edge and neither s_*_ack_o is asserted.
